// File: rtl/mu_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : mu_gpio_irq
// Brief    : APB GPIO controller with atomic set/clear/toggle, input
//            synchroniser and sticky edge-detect interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module mu_gpio_irq #(
    parameter int           N           = 8,
    parameter int           SYNC_STAGES = 2,
    parameter logic [N-1:0] OUT_RST     = '0,
    parameter logic [N-1:0] OE_RST      = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_apb_psel,
    input  logic          s_apb_penable,
    input  logic          s_apb_pwrite,
    input  logic [31:0]   s_apb_paddr,
    input  logic [31:0]   s_apb_pwdata,
    output logic          s_apb_pready,
    output logic [31:0]   s_apb_prdata,
    output logic [N-1:0]  gpio_out,
    output logic [N-1:0]  gpio_oe,
    input  logic [N-1:0]  gpio_in,
    output logic          irq
);

    localparam logic [3:0] c_REG_OUT  = 4'h0;
    localparam logic [3:0] c_REG_SET  = 4'h1;
    localparam logic [3:0] c_REG_CLR  = 4'h2;
    localparam logic [3:0] c_REG_TGL  = 4'h3;
    localparam logic [3:0] c_REG_OE   = 4'h4;
    localparam logic [3:0] c_REG_IN   = 4'h5;
    localparam logic [3:0] c_REG_EN   = 4'h6;
    localparam logic [3:0] c_REG_RISE = 4'h7;
    localparam logic [3:0] c_REG_FALL = 4'h8;
    localparam logic [3:0] c_REG_STAT = 4'h9;

    logic [N-1:0] r_out_q,  w_out_d;
    logic [N-1:0] r_oe_q,   w_oe_d;
    logic [N-1:0] r_en_q,   w_en_d;
    logic [N-1:0] r_rise_q, w_rise_d;
    logic [N-1:0] r_fall_q, w_fall_d;
    logic [N-1:0] r_stat_q, w_stat_d;
    logic [N-1:0] r_prev_q, w_prev_d;
    logic [N-1:0] r_sync_q [SYNC_STAGES];
    logic [N-1:0] w_sync_d [SYNC_STAGES];

    logic         w_wr;
    logic [3:0]   w_idx;
    logic [N-1:0] w_wdata;
    logic [N-1:0] w_s;
    logic [N-1:0] w_edges;
    logic [N-1:0] w_clr;
    logic [31:0]  w_rdata;
    logic         w_unused;

    assign w_wr     = s_apb_psel & s_apb_penable & s_apb_pwrite;
    assign w_idx    = s_apb_paddr[5:2];
    assign w_wdata  = s_apb_pwdata[N-1:0];
    assign w_s      = r_sync_q[SYNC_STAGES-1];
    assign w_edges  = (w_s & ~r_prev_q & r_rise_q) | (~w_s & r_prev_q & r_fall_q);
    assign w_unused = ^{s_apb_paddr[31:6], s_apb_paddr[1:0], s_apb_pwdata};

    always_comb begin
        w_out_d  = r_out_q;
        w_oe_d   = r_oe_q;
        w_en_d   = r_en_q;
        w_rise_d = r_rise_q;
        w_fall_d = r_fall_q;
        w_clr    = '0;
        if (w_wr) begin
            case (w_idx)
                c_REG_OUT:  w_out_d  = w_wdata;
                c_REG_SET:  w_out_d  = r_out_q | w_wdata;
                c_REG_CLR:  w_out_d  = r_out_q & ~w_wdata;
                c_REG_TGL:  w_out_d  = r_out_q ^ w_wdata;
                c_REG_OE:   w_oe_d   = w_wdata;
                c_REG_EN:   w_en_d   = w_wdata;
                c_REG_RISE: w_rise_d = w_wdata;
                c_REG_FALL: w_fall_d = w_wdata;
                c_REG_STAT: w_clr    = w_wdata;
                default:    ;
            endcase
        end
        // New edges are OR'd in after the clear so a coincident edge survives W1C
        w_stat_d = (r_stat_q & ~w_clr) | w_edges;
        w_prev_d = w_s;
        w_sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            w_sync_d[i] = r_sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q  <= OUT_RST;
            r_oe_q   <= OE_RST;
            r_en_q   <= '0;
            r_rise_q <= '0;
            r_fall_q <= '0;
            r_stat_q <= '0;
            r_prev_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= '0;
            end
        end else begin
            r_out_q  <= w_out_d;
            r_oe_q   <= w_oe_d;
            r_en_q   <= w_en_d;
            r_rise_q <= w_rise_d;
            r_fall_q <= w_fall_d;
            r_stat_q <= w_stat_d;
            r_prev_q <= w_prev_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= w_sync_d[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (s_apb_psel && !s_apb_pwrite && !rst) begin
            case (w_idx)
                c_REG_OUT:  w_rdata[N-1:0] = r_out_q;
                c_REG_OE:   w_rdata[N-1:0] = r_oe_q;
                c_REG_IN:   w_rdata[N-1:0] = w_s;
                c_REG_EN:   w_rdata[N-1:0] = r_en_q;
                c_REG_RISE: w_rdata[N-1:0] = r_rise_q;
                c_REG_FALL: w_rdata[N-1:0] = r_fall_q;
                c_REG_STAT: w_rdata[N-1:0] = r_stat_q;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign s_apb_prdata = w_rdata;
    assign s_apb_pready = 1'b1;
    assign gpio_out     = r_out_q;
    assign gpio_oe      = r_oe_q;
    assign irq          = |(r_stat_q & r_en_q);

endmodule
`default_nettype wire

// File: tb/tb_mu_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mu_gpio_irq
// Brief    : Self-checking bench for mu_gpio_irq against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mu_gpio_irq;

    localparam int         c_N       = 8;
    localparam int         c_SS      = 2;
    localparam logic [7:0] c_OUT_RST = 8'h5A;
    localparam logic [7:0] c_OE_RST  = 8'hC3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_in = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    mu_gpio_irq #(
        .N(c_N), .SYNC_STAGES(c_SS), .OUT_RST(c_OUT_RST), .OE_RST(c_OE_RST)
    ) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_paddr(paddr), .s_apb_pwdata(pwdata),
        .s_apb_pready(pready), .s_apb_prdata(prdata),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: register values plus the full history of sampled pins
    logic [7:0] m_out, m_oe, m_en, m_rise, m_fall, m_stat;
    logic [7:0] samples [$];
    int         cyc;

    // Synchronised view after k edges is the pin value sampled SYNC_STAGES edges earlier
    function automatic logic [7:0] s_at(input int k);
        if (k >= c_SS) return samples[k-c_SS];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        logic [7:0] s_b, p_b, edges, clr, wd;
        if (rst) begin
            m_out = c_OUT_RST; m_oe = c_OE_RST;
            m_en = 0; m_rise = 0; m_fall = 0; m_stat = 0;
            samples.delete();
            cyc = 0;
        end else begin
            s_b   = s_at(cyc);
            p_b   = s_at(cyc - 1);
            edges = (s_b & ~p_b & m_rise) | (~s_b & p_b & m_fall);
            clr   = 0;
            wd    = pwdata[7:0];
            if (psel && penable && pwrite) begin
                case (paddr[5:2])
                    4'h0: m_out  = wd;
                    4'h1: m_out  = m_out | wd;
                    4'h2: m_out  = m_out & ~wd;
                    4'h3: m_out  = m_out ^ wd;
                    4'h4: m_oe   = wd;
                    4'h6: m_en   = wd;
                    4'h7: m_rise = wd;
                    4'h8: m_fall = wd;
                    4'h9: clr    = wd;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | edges;
            samples.push_back(gpio_in);
            cyc++;
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[5:2])
            4'h0: return {24'h0, m_out};
            4'h4: return {24'h0, m_oe};
            4'h5: return {24'h0, s_at(cyc)};
            4'h6: return {24'h0, m_en};
            4'h7: return {24'h0, m_rise};
            4'h8: return {24'h0, m_fall};
            4'h9: return {24'h0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1 d = prdata;
        psel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd, v, a;

        // Reset behaviour, including the read path held at zero during reset
        repeat (3) @(negedge clk);
        psel = 1'b1; paddr = 32'h0;
        #1 check_val("prdata_in_rst", prdata, 32'h0);
        psel = 1'b0;
        rst = 1'b0;
        apb_read(32'h00, rd); check_val("rst_out", rd, {24'h0, c_OUT_RST});
        apb_read(32'h10, rd); check_val("rst_oe", rd, {24'h0, c_OE_RST});
        apb_read(32'h24, rd); check_val("rst_stat", rd, 32'h0);
        check_val("rst_irq", {31'h0, irq}, 32'h0);
        check_val("pready", {31'h0, pready}, 32'h1);

        // Atomic set/clear/toggle
        apb_write(32'h00, 32'hA5); check_val("out_wr", {24'h0, gpio_out}, 32'hA5);
        apb_write(32'h04, 32'h0F); check_val("out_set", {24'h0, gpio_out}, 32'hAF);
        apb_write(32'h08, 32'h81); check_val("out_clr", {24'h0, gpio_out}, 32'h2E);
        apb_write(32'h0C, 32'hFF); check_val("out_tgl", {24'h0, gpio_out}, 32'hD1);
        apb_read(32'h04, rd); check_val("rd_set", rd, 32'h0);
        apb_read(32'h08, rd); check_val("rd_clr", rd, 32'h0);
        apb_read(32'h0C, rd); check_val("rd_tgl", rd, 32'h0);

        // Synchroniser latency on pin 3
        @(negedge clk); gpio_in[3] = 1'b1;
        apb_read(32'h14, rd); check_val("sync_early", {31'h0, rd[3]}, 32'h0);
        apb_read(32'h14, rd); check_val("sync_ontime", {31'h0, rd[3]}, 32'h1);

        // Rising-edge interrupt on pin 3
        @(negedge clk); gpio_in[3] = 1'b0;
        idle(5);
        apb_write(32'h1C, 32'h08);
        apb_write(32'h18, 32'h08);
        @(negedge clk); gpio_in[3] = 1'b1;
        apb_read(32'h24, rd); check_val("stat_e1", rd, 32'h0);
        apb_read(32'h24, rd); check_val("stat_e2", rd, 32'h0);
        apb_read(32'h24, rd); check_val("stat_e3", rd, 32'h08);
        check_val("irq_set", {31'h0, irq}, 32'h1);
        @(negedge clk); gpio_in[3] = 1'b0;
        idle(5);
        apb_read(32'h24, rd); check_val("stat_fall_ign", rd, 32'h08);
        apb_write(32'h24, 32'h08);
        apb_read(32'h24, rd); check_val("stat_w1c", rd, 32'h0);
        check_val("irq_clr", {31'h0, irq}, 32'h0);

        // Set wins over a coincident W1C on pin 0 (both edges selected)
        apb_write(32'h1C, 32'h01);
        apb_write(32'h20, 32'h01);
        @(negedge clk); gpio_in[0] = 1'b1;
        idle(5);
        apb_read(32'h24, rd); check_val("stat0_rise", rd, 32'h01);
        @(negedge clk); gpio_in[0] = 1'b0;
        apb_write(32'h24, 32'h01);
        apb_read(32'h24, rd); check_val("set_wins", rd, 32'h01);
        apb_write(32'h24, 32'h01);
        apb_read(32'h24, rd); check_val("stat0_clr", rd, 32'h0);

        // Width and decode
        apb_write(32'h00, 32'hFFFFFFFF);
        apb_read(32'h00, rd); check_val("out_width", rd, 32'h000000FF);
        apb_write(32'h3C, 32'h12345678);
        apb_read(32'h00, rd); check_val("unmapped_wr", rd, 32'h000000FF);
        apb_read(32'h3C, rd); check_val("unmapped_rd", rd, 32'h0);

        // Reset asserted during the access phase discards the write
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
        apb_read(32'h00, rd); check_val("rst_mid_xfer", rd, {24'h0, c_OUT_RST});

        // Randomised traffic against the model
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) gpio_in = 8'($urandom);
            v = $urandom;
            a = {v[31:6], 4'($urandom_range(0, 15)), v[1:0]};
            if ($urandom_range(0, 1) == 1) begin
                apb_write(a, $urandom);
            end else begin
                apb_read(a, rd);
                check_val("rand_rd", rd, m_read(a));
            end
            check_val("rand_out", {24'h0, gpio_out}, {24'h0, m_out});
            check_val("rand_oe", {24'h0, gpio_oe}, {24'h0, m_oe});
            check_val("rand_irq", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
